// File: rtl/id_scoreboard_pkg.sv
// Shared constants for the ID-stage register scoreboard: forward-select
// encodings and default pipeline latencies.
package id_scoreboard_pkg;

   localparam int FWD_SEL_GPR   = 0;
   localparam int FWD_SEL_EX    = 1;
   localparam int FWD_SEL_MEM   = 2;

   localparam int DEF_FWD_DEPTH = 2;
   localparam int DEF_ALU_LAT   = 1;
   localparam int DEF_LD_LAT    = 2;
   localparam int DEF_FLUSH_AGE = 1;

endpackage

// File: rtl/id_sb_entry.sv
// One GPR's in-flight write tracker: busy flag, age since issue and the age
// at which its result becomes forwardable.
module id_sb_entry
   import id_scoreboard_pkg::*;
#(
   parameter int CNT_W     = 2,
   parameter int FWD_DEPTH = DEF_FWD_DEPTH,
   parameter int FLUSH_AGE = DEF_FLUSH_AGE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             hold,
   input  logic             load_en,
   input  logic [CNT_W-1:0] load_lat,
   output logic             busy,
   output logic [CNT_W-1:0] age,
   output logic [CNT_W-1:0] lat
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FWD_DEPTH);
   localparam logic [CNT_W-1:0] FLUSH_C = CNT_W'(FLUSH_AGE);

   logic             busy_reg, busy_next, aged_busy;
   logic [CNT_W-1:0] age_reg, age_next, aged_age;
   logic [CNT_W-1:0] lat_reg, lat_next;

   always_comb begin
      // Plain one-cycle advance; the oldest stage drops into the GPR file.
      aged_busy = busy_reg;
      aged_age  = age_reg;
      if (busy_reg) begin
         if (age_reg == DEPTH_C) begin
            aged_busy = 1'b0;
            aged_age  = '0;
         end else begin
            aged_age = age_reg + 1'b1;
         end
      end

      busy_next = busy_reg;
      age_next  = age_reg;
      lat_next  = lat_reg;
      if (flush) begin
         if (age_reg <= FLUSH_C) begin
            busy_next = 1'b0;
            age_next  = '0;
         end else begin
            busy_next = aged_busy;
            age_next  = aged_age;
         end
      end else if (!hold) begin
         busy_next = aged_busy;
         age_next  = aged_age;
         if (load_en) begin
            busy_next = 1'b1;
            age_next  = CNT_W'(1);
            lat_next  = load_lat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_reg <= 1'b0;
         age_reg  <= '0;
         lat_reg  <= '0;
      end else begin
         busy_reg <= busy_next;
         age_reg  <= age_next;
         lat_reg  <= lat_next;
      end
   end

   assign busy = busy_reg;
   assign age  = age_reg;
   assign lat  = lat_reg;

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage register scoreboard: per-source forward select and hazard stall
// derived from the age/latency of every in-flight GPR write.
module id_scoreboard
   import id_scoreboard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int FWD_DEPTH  = DEF_FWD_DEPTH,
   parameter int ALU_LAT    = DEF_ALU_LAT,
   parameter int LD_LAT     = DEF_LD_LAT,
   parameter int FLUSH_AGE  = DEF_FLUSH_AGE,
   localparam int NUM_REGS  = 2**REG_ADDR_W,
   localparam int CNT_W     = $clog2(FWD_DEPTH+1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          IssueEn,
   input  logic                          IssueGPRWE_,
   input  logic [REG_ADDR_W-1:0]         IssueDstAddr,
   input  logic                          IssueIsLoad,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] SrcAddr,
   input  logic [NUM_SRC-1:0]            SrcUsed,
   input  logic                          Hold,
   input  logic                          Flush,
   output logic                          Stall,
   output logic [NUM_SRC*CNT_W-1:0]      FwdSel,
   output logic                          IssueAck,
   output logic [NUM_REGS-1:0]           BusyVec
);

   if (!(ALU_LAT >= 1 && ALU_LAT <= LD_LAT && LD_LAT <= FWD_DEPTH && FLUSH_AGE < FWD_DEPTH)) begin : g_bad_params
      $error("id_scoreboard: illegal latency/depth parameter combination");
   end

   logic [CNT_W-1:0]   age_arr [NUM_REGS];
   logic [CNT_W-1:0]   lat_arr [NUM_REGS];
   logic [NUM_SRC-1:0] src_hazard;
   logic [CNT_W-1:0]   issue_lat;
   logic               issue_we;

   assign IssueAck  = IssueEn & ~Stall & ~Hold & ~Flush;
   assign issue_we  = IssueAck & ~IssueGPRWE_;
   assign issue_lat = IssueIsLoad ? CNT_W'(LD_LAT) : CNT_W'(ALU_LAT);

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      id_sb_entry #(
         .CNT_W     (CNT_W),
         .FWD_DEPTH (FWD_DEPTH),
         .FLUSH_AGE (FLUSH_AGE)
      ) u_entry (
         .clk      (clk),
         .reset    (reset),
         .flush    (Flush),
         .hold     (Hold),
         .load_en  (issue_we && (IssueDstAddr == REG_ADDR_W'(gi))),
         .load_lat (issue_lat),
         .busy     (BusyVec[gi]),
         .age      (age_arr[gi]),
         .lat      (lat_arr[gi])
      );
   end

   // A source hazards only while its producer has not yet reached its latency.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_ADDR_W-1:0] src_addr;
      logic                  src_busy;
      assign src_addr       = SrcAddr[gi*REG_ADDR_W +: REG_ADDR_W];
      assign src_busy       = BusyVec[src_addr];
      assign src_hazard[gi] = SrcUsed[gi] & src_busy & (age_arr[src_addr] < lat_arr[src_addr]);
      assign FwdSel[gi*CNT_W +: CNT_W] = src_busy ? age_arr[src_addr] : CNT_W'(FWD_SEL_GPR);
   end

   assign Stall = |src_hazard;

endmodule
